cargador_programa: RTL and testbench

Program loader and writer for the instruction memory; the datapath is the reader of that memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS instructions.
- Writes each instruction into the instruction-memory write port.
- Holds the datapath in reset until the whole image is loaded, then releases it to fetch from BASE_ADDR.

---
 rtl/cargador_programa.sv | 214 +++++++++++++++++++++
 tb/tb_cargador_programa.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cargador_programa.sv
// cargador_programa: program loader for the instruction memory.
//
// The loader takes a byte stream over a valid/ready handshake. The first two
// bytes are the word count N, high byte first. The data bytes are then packed
// into big-endian 32-bit words, and each word is written to the
// instruction-memory write port. The datapath is held in reset
// (o_cpu_hold=1) until the whole image has been written.
//
// Build option:
//   CARGADOR_CHECKSUM_EN - when defined, one trailing byte follows the image.
//                          It must equal the XOR of all data bytes, otherwise
//                          the load ends in ERROR.
//
// Ports:
//   clk, reset              - clock and asynchronous active-low reset
//   i_start                 - begins a load (only in IDLE, DONE or ERROR)
//   i_byte_valid, i_byte    - byte source
//   o_byte_ready            - byte accepted on an edge where valid && ready
//   o_mem_we/addr/wdata     - instruction-memory write port
//   o_cpu_hold              - keeps the datapath in reset
//   o_busy/o_done/o_error   - load status
//   o_word_count            - words written in the current load
//
// States:
//   IDLE  | after reset, waiting for i_start
//   HDR   | receiving the 2-byte word count
//   DATA  | receiving the 4 bytes of a word
//   WRITE | one-cycle memory write of the assembled word
//   CHK   | receiving the trailing checksum byte (checksum build only)
//   DONE  | image loaded, datapath released
//   ERROR | load aborted, datapath kept in reset
module cargador_programa #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef CARGADOR_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        xfer;
    logic [15:0] hdr_len;

    assign xfer    = i_byte_valid && ready_q;
    assign hdr_len = {len_q[15:8], i_byte};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        len_d      = len_q;
        idx_d      = idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef CARGADOR_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d    = S_HDR;
                    byte_cnt_d = 2'd0;
                    idx_d      = 16'd0;
`ifdef CARGADOR_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (byte_cnt_q == 2'd0) begin
                        len_d[15:8] = i_byte;
                        byte_cnt_d  = 2'd1;
                    end else begin
                        len_d      = hdr_len;
                        byte_cnt_d = 2'd0;
                        if (hdr_len == 16'd0 || hdr_len > 16'(MAX_WORDS))
                            state_d = S_ERROR;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = {word_q[23:0], i_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CARGADOR_CHECKSUM_EN
                    csum_d     = csum_q ^ i_byte;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Strobe, address and data are registered together so
                        // they line up with the WRITE cycle.
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        wdata_d = word_d;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 16'd1;
                if (idx_q == len_q - 16'd1) begin
`ifdef CARGADOR_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
`ifdef CARGADOR_CHECKSUM_EN
                if (xfer)
                    state_d = (i_byte == csum_q) ? S_DONE : S_ERROR;
`else
                state_d = S_ERROR;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so that they are
        // registered and change in the same cycle as the state.
        ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
        busy_d  = ready_d || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
        hold_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            len_q      <= 16'd0;
            idx_q      <= 16'd0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef CARGADOR_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign o_byte_ready = ready_q;
    assign o_mem_we     = we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_cpu_hold   = hold_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_word_count = idx_q;

endmodule

// File: tb/tb_cargador_programa.sv
module tb_cargador_programa;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_cpu_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_word_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int nw;

    cargador_programa #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte),
        .o_byte_ready(o_byte_ready), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_cpu_hold(o_cpu_hold), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_word_count(o_word_count)
    );

    always #5 clk = ~clk;

    // A write happens on the edge that ends a cycle with o_mem_we high.
    always @(negedge clk) begin
        if (o_mem_we) begin
            wr_addr.push_back(o_mem_addr);
            wr_data.push_back(o_mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called and returning on a negedge; valid is left high afterwards.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        repeat (gap) begin
            i_byte_valid = 1'b0;
            @(negedge clk);
        end
        i_byte_valid = 1'b1;
        i_byte       = b;
        ok           = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            ok = o_byte_ready;
            @(negedge clk);
        end
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input logic [7:0] q[$], input int gap);
        foreach (q[i]) send_byte(q[i], gap);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; i_start = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_hold",  32'(o_cpu_hold),   32'd1);
        check("rst_busy",  32'(o_busy),       32'd0);
        check("rst_done",  32'(o_done),       32'd0);
        check("rst_err",   32'(o_error),      32'd0);
        check("rst_ready", 32'(o_byte_ready), 32'd0);
        check("rst_we",    32'(o_mem_we),     32'd0);
        check("rst_wc",    32'(o_word_count), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two-word load with a continuously valid source.
        pulse_start();
        load('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20}, 0);
        check("t1_we",    32'(o_mem_we), 32'd1);
        check("t1_addr",  o_mem_addr,    32'd4);
        check("t1_wdata", o_mem_wdata,   32'h0109_5020);
        check("t1_done_early", 32'(o_done), 32'd0);
        i_byte_valid = 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
        send_byte(8'h55, 0);
        i_byte_valid = 1'b0;
`else
        @(negedge clk);
`endif
        check("t1_done",  32'(o_done),       32'd1);
        check("t1_hold",  32'(o_cpu_hold),   32'd0);
        check("t1_wc",    32'(o_word_count), 32'd2);
        check("t1_ready", 32'(o_byte_ready), 32'd0);
        check("t1_nwr",   32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t1_a0", wr_addr[0], 32'd0);
            check("t1_d0", wr_data[0], 32'h2008_0005);
            check("t1_a1", wr_addr[1], 32'd4);
            check("t1_d1", wr_data[1], 32'h0109_5020);
        end

        // Zero and oversized headers.
        nw = wr_addr.size();
        pulse_start();
        load('{8'h00, 8'h00}, 0);
        i_byte_valid = 1'b0;
        check("t2_err0",   32'(o_error),      32'd1);
        check("t2_hold0",  32'(o_cpu_hold),   32'd1);
        check("t2_ready0", 32'(o_byte_ready), 32'd0);
        check("t2_busy0",  32'(o_busy),       32'd0);
        pulse_start();
        check("t2_restart_busy", 32'(o_busy),  32'd1);
        check("t2_restart_err",  32'(o_error), 32'd0);
        load('{8'h01, 8'h01}, 0);
        i_byte_valid = 1'b0;
        check("t2_err257",  32'(o_error),    32'd1);
        check("t2_hold257", 32'(o_cpu_hold), 32'd1);
        check("t2_nwr",     32'(wr_addr.size()), 32'(nw));

        // One-word load with valid toggling every other cycle.
        nw = wr_addr.size();
        pulse_start();
        load('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1);
        check("t3_we",    32'(o_mem_we), 32'd1);
        check("t3_addr",  o_mem_addr,    32'd0);
        check("t3_wdata", o_mem_wdata,   32'hAABB_CCDD);
        i_byte_valid = 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
        send_byte(8'h00, 0);
        i_byte_valid = 1'b0;
`else
        @(negedge clk);
`endif
        check("t3_done", 32'(o_done),       32'd1);
        check("t3_wc",   32'(o_word_count), 32'd1);
        check("t3_nwr",  32'(wr_addr.size()), 32'(nw + 1));

        // Reset after three data bytes of the second word.
        nw = wr_addr.size();
        pulse_start();
        load('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77}, 0);
        i_byte_valid = 1'b0;
        check("t4_nwr_pre", 32'(wr_addr.size()), 32'(nw + 1));
        check("t4_d0", wr_data[wr_data.size() - 1], 32'h1122_3344);
        reset = 1'b0;
        #1;
        check("t4_hold",  32'(o_cpu_hold),   32'd1);
        check("t4_busy",  32'(o_busy),       32'd0);
        check("t4_we",    32'(o_mem_we),     32'd0);
        check("t4_ready", 32'(o_byte_ready), 32'd0);
        check("t4_wc",    32'(o_word_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_nwr_post", 32'(wr_addr.size()), 32'(nw + 1));
        check("t4_idle_busy", 32'(o_busy), 32'd0);

        // i_start during DATA is ignored; i_start in DONE restarts.
        pulse_start();
        load('{8'h00, 8'h01, 8'h12, 8'h34}, 0);
        i_byte_valid = 1'b0;
        pulse_start();
        check("t5_busy_mid", 32'(o_busy),       32'd1);
        check("t5_wc_mid",   32'(o_word_count), 32'd0);
        load('{8'h56, 8'h78}, 0);
        check("t5_wdata", o_mem_wdata, 32'h1234_5678);
        i_byte_valid = 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
        send_byte(8'h08, 0);
        i_byte_valid = 1'b0;
`else
        @(negedge clk);
`endif
        check("t5_done", 32'(o_done),     32'd1);
        check("t5_hold", 32'(o_cpu_hold), 32'd0);
        pulse_start();
        check("t5_rs_done", 32'(o_done),       32'd0);
        check("t5_rs_hold", 32'(o_cpu_hold),   32'd1);
        check("t5_rs_busy", 32'(o_busy),       32'd1);
        check("t5_rs_wc",   32'(o_word_count), 32'd0);

`ifdef CARGADOR_CHECKSUM_EN
        // Wrong trailing checksum.
        load('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78}, 0);
        i_byte_valid = 1'b0;
        send_byte(8'h09, 0);
        i_byte_valid = 1'b0;
        check("t6_err",  32'(o_error),    32'd1);
        check("t6_hold", 32'(o_cpu_hold), 32'd1);
        check("t6_done", 32'(o_done),     32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
